imem_boot_ctrl: RTL

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

---
 rtl/imem_boot_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl
//
// Boot loader for the private instruction memories of a multi-core cluster.
// A load command selects one core, holds that core in reset for a fixed
// number of cycles, and then streams instruction words from a valid/ready
// source into the core's imem at consecutive word addresses. When the last
// word has been written, the core is released from reset and a done pulse
// is issued. Bad commands and aborts report an err pulse instead.
//
// Parameters
//   I_ADDRESSWIDTH  imem word-address width
//   NUM_CORES       number of cores with a private imem
//   HOLD_CYCLES     cycles a core is held in reset before its first write (>=1)
//
// Ports
//   clk             clock, all logic on the rising edge
//   resetn          synchronous, active-low reset
//   cmd_start       single-cycle load request (honoured only while idle)
//   cmd_core        target core index
//   cmd_base        first imem word address
//   cmd_len         number of words to load
//   cmd_abort       cancels the load in progress (hold or load phase)
//   in_data         instruction word
//   in_valid        in_data valid
//   in_ready        controller accepts in_data
//   boot_iaddr      imem word address, zero-extended to 32 bits
//   boot_idata      imem write data
//   boot_iwe        per-core imem write enable, at most one bit set
//   core_resetn     per-core active-low reset to the fetch/pipeline
//   busy            high whenever the controller is not idle
//   done            one-cycle pulse on successful completion
//   err             one-cycle pulse on a rejected command or an abort
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module imem_boot_ctrl #(
    parameter int I_ADDRESSWIDTH = 14,
    parameter int NUM_CORES      = 4,
    parameter int HOLD_CYCLES    = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      cmd_start,
    input  logic [1:0]                cmd_core,
    input  logic [I_ADDRESSWIDTH-1:0] cmd_base,
    input  logic [I_ADDRESSWIDTH:0]   cmd_len,
    input  logic                      cmd_abort,
    input  logic [31:0]               in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [31:0]               boot_iaddr,
    output logic [31:0]               boot_idata,
    output logic [NUM_CORES-1:0]      boot_iwe,
    output logic [NUM_CORES-1:0]      core_resetn,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int AW = I_ADDRESSWIDTH;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_LOAD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
    localparam logic [AW:0]   COUNT_ONE   = {{AW{1'b0}}, 1'b1};
    // 2^AW expressed at AW+2 bits so base+len can be compared without wrap
    localparam logic [AW+1:0] ADDR_SPAN   = {2'b01, {AW{1'b0}}};
    localparam logic [31:0]   NUM_CORES_U = 32'(NUM_CORES);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]    state_q;
    logic [1:0]    core_q;
    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic [AW:0]   count_q;
    logic [HW-1:0] hold_q;

    // -------------------------------------------------------------------------
    // Command validation and datapath helpers
    // -------------------------------------------------------------------------
    logic [AW+1:0]        cmd_end;
    logic                 cmd_bad;
    logic [NUM_CORES-1:0] cmd_sel;
    logic [NUM_CORES-1:0] core_sel;
    logic                 accept;
    logic [AW:0]          count_inc;
    logic [AW-1:0]        wr_addr;
    logic                 last_word;

    // One extra bit of headroom beyond AW+1 so the end address never wraps,
    // even for the largest base and length the ports can express.
    assign cmd_end   = {1'b0, cmd_len} + {2'b00, cmd_base};
    assign cmd_bad   = (cmd_len == '0)
                    || ({30'b0, cmd_core} >= NUM_CORES_U)
                    || (cmd_end > ADDR_SPAN);

    assign cmd_sel   = NUM_CORES'(1) << cmd_core;
    assign core_sel  = NUM_CORES'(1) << core_q;

    assign accept    = in_valid & in_ready;
    assign count_inc = count_q + COUNT_ONE;
    // Validation guarantees base+count stays below 2^AW, so the truncated
    // sum is the exact word address.
    assign wr_addr   = base_q + count_q[AW-1:0];
    assign last_word = (count_inc == len_q);

    // -------------------------------------------------------------------------
    // Controller
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            core_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            in_ready    <= 1'b0;
            boot_iaddr  <= '0;
            boot_idata  <= '0;
            boot_iwe    <= '0;
            core_resetn <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            // Pulsed outputs default low every cycle.
            boot_iwe <= '0;
            done     <= 1'b0;
            err      <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (cmd_start) begin
                        if (cmd_bad) begin
                            err <= 1'b1;
                        end else begin
                            core_q      <= cmd_core;
                            base_q      <= cmd_base;
                            len_q       <= cmd_len;
                            count_q     <= '0;
                            hold_q      <= '0;
                            core_resetn <= core_resetn & ~cmd_sel;
                            busy        <= 1'b1;
                            state_q     <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (cmd_abort) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        // in_ready is registered, so it is raised on the
                        // same edge that enters LOAD.
                        in_ready <= 1'b1;
                        state_q  <= ST_LOAD;
                    end else begin
                        hold_q <= hold_q + HOLD_ONE;
                    end
                end

                ST_LOAD: begin
                    if (cmd_abort) begin
                        // A word handshaken in this same cycle is dropped.
                        in_ready <= 1'b0;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (accept) begin
                        boot_iwe   <= core_sel;
                        boot_idata <= in_data;
                        boot_iaddr <= 32'(wr_addr);
                        count_q    <= count_inc;
                        if (last_word) begin
                            in_ready <= 1'b0;
                            state_q  <= ST_RELEASE;
                        end
                    end
                end

                ST_RELEASE: begin
                    // The final write is on the bus during this cycle, so the
                    // core leaves reset strictly after it.
                    core_resetn <= core_resetn | core_sel;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_q     <= ST_IDLE;
                end

                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
